// File: rtl/intan_pkg.sv
// intan_pkg: shared state encoding, header default and byte-select helpers
// for the intan_pack frame builder.
package intan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_HD0  = 4'd1,
        ST_HD1  = 4'd2,
        ST_ID   = 4'd3,
        ST_SEQ  = 4'd4,
        ST_RDH  = 4'd5,
        ST_WTH  = 4'd6,
        ST_TXH  = 4'd7,
        ST_RDL  = 4'd8,
        ST_WTL  = 4'd9,
        ST_TXL  = 4'd10,
        ST_SUM  = 4'd11,
        ST_DONE = 4'd12
    } state_t;

    localparam logic [15:0] HEAD_DEFAULT = 16'h55AA;

    // Bit positions of the two channel FIFOs in fifo_rxen / fifo_empty.
    localparam int CH_HI = 1;
    localparam int CH_LO = 0;

    // Pick the high or low FIFO byte out of the packed read-data word.
    function automatic logic [7:0] rxd_byte(input logic [15:0] rxd, input logic sel_hi);
        return sel_hi ? rxd[15:8] : rxd[7:0];
    endfunction

    // One step of the running payload checksum.
    function automatic logic [7:0] sum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/intan_pack_if.sv
// intan_pack_if: channel-FIFO read port and byte-stream output of the packer.
// master = packer side, slave = FIFO/sink side.
interface intan_pack_if;
    logic [1:0]  fifo_rxen;
    logic [15:0] fifo_rxd;
    logic [1:0]  fifo_empty;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output fifo_rxen,
        output tx_data,
        output tx_valid,
        input  fifo_rxd,
        input  fifo_empty,
        input  tx_ready
    );

    modport slave (
        input  fifo_rxen,
        input  tx_data,
        input  tx_valid,
        output fifo_rxd,
        output fifo_empty,
        output tx_ready
    );
endinterface

// File: rtl/intan_pack.sv
// intan_pack: builds one frame per request:
//   HEAD[15:8], HEAD[7:0], dev_id, seq, BYTES_PER_CH high-FIFO bytes,
//   BYTES_PER_CH low-FIFO bytes, [XOR checksum].
// Optional feature macro: INTAN_PACK_SUM_EN adds the trailing checksum byte.
// tx_valid/tx_data/fd_pack are registered from the next state; fifo_rxen is
// decoded from the current state so read data lands exactly in the wait state.
module intan_pack
    import intan_pkg::*;
#(
    parameter int unsigned BYTES_PER_CH = 64,
    parameter logic [15:0] HEAD         = HEAD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fs_pack,
    output logic         fd_pack,
    input  logic [7:0]   dev_id,
    intan_pack_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(BYTES_PER_CH - 32'd1);

`ifdef INTAN_PACK_SUM_EN
    localparam state_t ST_AFTER_LO = ST_SUM;
`else
    localparam state_t ST_AFTER_LO = ST_DONE;
`endif

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] seq_r;
    logic [7:0] cnt_r;
    logic [7:0] dev_id_r;
    logic [7:0] tx_data_r;
    logic [7:0] tx_data_nxt_s;
    logic       tx_valid_r;
    logic       tx_valid_nxt_s;
    logic       fd_pack_r;
    logic       fd_pack_nxt_s;
    logic       xfer_s;
    logic       last_s;
    logic       payload_xfer_s;
    logic [1:0] rxen_s;

    assign xfer_s         = tx_valid_r & bus.tx_ready;
    assign last_s         = (cnt_r == LAST_IDX);
    assign payload_xfer_s = xfer_s & ((state_r == ST_TXH) | (state_r == ST_TXL));

`ifdef INTAN_PACK_SUM_EN
    logic [7:0] sum_r;
    logic [7:0] sum_byte_s;

    assign sum_byte_s = sum_step(sum_r, tx_data_r);

    // Running XOR of payload bytes, cleared between frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r <= 8'h00;
        end else if (state_r == ST_IDLE) begin
            sum_r <= 8'h00;
        end else if (payload_xfer_s) begin
            sum_r <= sum_step(sum_r, tx_data_r);
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: header bytes advance on transfer, channel bytes walk read/wait/send
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: if (fs_pack) state_nxt_s = ST_HD0; else state_nxt_s = ST_IDLE;
            ST_HD0:  if (xfer_s)  state_nxt_s = ST_HD1; else state_nxt_s = ST_HD0;
            ST_HD1:  if (xfer_s)  state_nxt_s = ST_ID;  else state_nxt_s = ST_HD1;
            ST_ID:   if (xfer_s)  state_nxt_s = ST_SEQ; else state_nxt_s = ST_ID;
            ST_SEQ:  if (xfer_s)  state_nxt_s = ST_RDH; else state_nxt_s = ST_SEQ;
            ST_RDH:  if (!bus.fifo_empty[CH_HI]) state_nxt_s = ST_WTH; else state_nxt_s = ST_RDH;
            ST_WTH:  state_nxt_s = ST_TXH;
            ST_TXH: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = ST_RDL;
                end else if (xfer_s) begin
                    state_nxt_s = ST_RDH;
                end else begin
                    state_nxt_s = ST_TXH;
                end
            end
            ST_RDL:  if (!bus.fifo_empty[CH_LO]) state_nxt_s = ST_WTL; else state_nxt_s = ST_RDL;
            ST_WTL:  state_nxt_s = ST_TXL;
            ST_TXL: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = ST_AFTER_LO;
                end else if (xfer_s) begin
                    state_nxt_s = ST_RDL;
                end else begin
                    state_nxt_s = ST_TXL;
                end
            end
`ifdef INTAN_PACK_SUM_EN
            ST_SUM:  if (xfer_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_SUM;
`endif
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; held bytes stay put while stalled
    always_comb begin
        tx_valid_nxt_s = 1'b0;
        tx_data_nxt_s  = 8'h00;
        fd_pack_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_HD0: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = HEAD[15:8];
            end
            ST_HD1: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = HEAD[7:0];
            end
            ST_ID: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = dev_id_r;
            end
            ST_SEQ: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = seq_r;
            end
            ST_TXH: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = (state_r == ST_WTH) ? rxd_byte(bus.fifo_rxd, 1'b1) : tx_data_r;
            end
            ST_TXL: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = (state_r == ST_WTL) ? rxd_byte(bus.fifo_rxd, 1'b0) : tx_data_r;
            end
`ifdef INTAN_PACK_SUM_EN
            ST_SUM: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = (state_r == ST_TXL) ? sum_byte_s : tx_data_r;
            end
`endif
            ST_DONE: begin
                fd_pack_nxt_s = 1'b1;
            end
            default: begin
                tx_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Single-cycle FIFO read strobe, only when the selected FIFO has data
    always_comb begin
        rxen_s = 2'b00;
        if ((state_r == ST_RDH) && !bus.fifo_empty[CH_HI]) begin
            rxen_s[CH_HI] = 1'b1;
        end else if ((state_r == ST_RDL) && !bus.fifo_empty[CH_LO]) begin
            rxen_s[CH_LO] = 1'b1;
        end else begin
            rxen_s = 2'b00;
        end
    end

    // Registered stream outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            fd_pack_r  <= 1'b0;
        end else begin
            tx_valid_r <= tx_valid_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            fd_pack_r  <= fd_pack_nxt_s;
        end
    end

    // Frame bookkeeping: device id capture, payload byte count, sequence number
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_id_r <= 8'h00;
            cnt_r    <= 8'h00;
            seq_r    <= 8'h00;
        end else begin
            if ((state_r == ST_IDLE) && fs_pack) begin
                dev_id_r <= dev_id;
            end else begin
                dev_id_r <= dev_id_r;
            end
            if (state_r == ST_IDLE) begin
                cnt_r <= 8'h00;
            end else if (payload_xfer_s) begin
                cnt_r <= last_s ? 8'h00 : (cnt_r + 8'd1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == ST_DONE) begin
                seq_r <= seq_r + 8'd1;
            end else begin
                seq_r <= seq_r;
            end
        end
    end

    assign bus.fifo_rxen = rxen_s;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_valid  = tx_valid_r;
    assign fd_pack       = fd_pack_r;

endmodule
